mdr_unit: RTL and testbench
===========================

Name: mdr_unit

Overview:
- Parametrised memory data register (MDR) with a sequential memory handshake.
- Inputs:
  - loaded from the internal bus (register transfer) when not reading;
  - on read, loaded from memory after a variable-latency ack, with byte/halfword lane extraction and sign or zero extension.
- Drives a registered write-data path back to memory.
- Sits between the datapath bus and the memory port; handshakes with the control unit through busy/done.

Parameters:
- DATA_W, 32, data width in bits (multiple of 16, minimum 16).
- TIMEOUT, 15, maximum wait cycles for mem_ack before abort (at least 1).
- CNT_W, $clog2(TIMEOUT+1), width of the wait counter (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-high reset
- bus_mux_out  in  DATA_W  datapath bus value
- mdr_in  in  1  load MDR from bus_mux_out (IDLE only)
- read  in  1  start memory read (sampled in IDLE)
- write  in  1  start memory write of current MDR (sampled in IDLE)
- size  in  2  access size: 00 byte, 01 half, 1x word
- sign_ext  in  1  1 = sign-extend sub-word reads, 0 = zero-extend
- addr_lo  in  2  low address bits for lane select
- mem_data_in  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion strobe
- mem_rd  out  1  read request, held until ack or timeout
- mem_wr  out  1  write request, held until ack or timeout
- mem_data_out  out  DATA_W  write data (equals mdr_q)
- mdr_q  out  DATA_W  MDR contents
- busy  out  1  high in RD_WAIT, WR_WAIT
- done  out  1  one-cycle pulse in DONE
- timeout_err  out  1  sticky; set on abort, cleared on next accepted read/write

Behaviour:
- Reset (clr=1, async):
  - state=IDLE; mdr_q=0, counter=0.
  - mem_rd=0, mem_wr=0, busy=0, done=0, timeout_err=0.
  - Reset mid-transaction aborts immediately; no done pulse.
- FSM states are IDLE, RD_WAIT, WR_WAIT, DONE. All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- IDLE:
  - Priority: read > write > mdr_in.
  - read=1: capture size, sign_ext, addr_lo; counter=0; clear timeout_err; go to RD_WAIT.
  - write=1 (read=0): counter=0; clear timeout_err; go to WR_WAIT.
  - mdr_in=1 alone: mdr_q <= bus_mux_out at the edge; stay in IDLE.
  - read and mdr_in together: the read wins and the bus value is discarded.
- RD_WAIT:
  - mem_rd=1.
  - On mem_ack=1: mdr_q <= extract(mem_data_in) and go to DONE. Minimum latency is 2 edges from read to done (ack on the first RD_WAIT cycle).
  - Otherwise the counter increments. On reaching TIMEOUT without ack: set timeout_err, leave mdr_q unchanged, go to DONE.
  - An ack arriving in the same cycle as the timeout is honoured; no error is set.
- WR_WAIT:
  - mem_wr=1; mem_data_out=mdr_q, stable throughout.
  - Ack and timeout follow the same rules as RD_WAIT.
- DONE: done=1 for exactly one cycle; return to IDLE. read, write and mdr_in are ignored during DONE.
- While busy, all read, write and mdr_in inputs are ignored. A stray mem_ack in IDLE or DONE is ignored.
- Extraction uses the captured size, sign_ext and addr_lo:
  - Byte: lane = mem_data_in[8*addr_lo +: 8], extended to DATA_W.
  - Half: lane = mem_data_in[16*addr_lo[1] +: 16], extended; addr_lo[0] is ignored (no alignment fault).
  - Word: full mem_data_in; sign_ext is ignored.
  - When DATA_W>32, byte/half lane select stays within the low 32 bits.
  - Extension fills the upper bits with the lane MSB (sign_ext=1) or 0.

Decomposition:
- Shared package mdr_pkg holds:
  - the state enum (IDLE, RD_WAIT, WR_WAIT, DONE);
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
- One combinational sub-module, mdr_extract: parameter DATA_W; inputs data, size, sign_ext, addr_lo; output the extended value. It is unit-testable in isolation.
- FSM, counter and registers live in mdr_unit.

Test Plan:
- Bus load: IDLE, mdr_in=1, bus_mux_out=32'hDEADBEEF → next edge mdr_q=32'hDEADBEEF; busy=0, done=0.
- Word read with 3-cycle latency:
  - Stimulus: read=1 size=10; mem_ack on the 3rd RD_WAIT cycle with mem_data_in=32'h12345678.
  - Response: mem_rd high for exactly 3 cycles; mdr_q=32'h12345678; one done pulse; timeout_err=0.
- Byte reads:
  - Stimulus: read, size=00, addr_lo=2, mem_data_in=32'h00A50000, immediate ack.
  - sign_ext=1 → mdr_q=32'hFFFFFFA5.
  - Repeat with sign_ext=0 → mdr_q=32'h000000A5.
- Half read and write:
  - Half read with size=01, addr_lo=3, sign_ext=1, data=32'h80010000 → mdr_q=32'hFFFF8001.
  - Then write=1 → mem_wr high and mem_data_out=32'hFFFF8001 until ack, then done.
- Timeout:
  - Stimulus: TIMEOUT=15, read, never ack.
  - Response: mem_rd high for 15 cycles; timeout_err=1; mdr_q unchanged; one done pulse.
  - A following write clears timeout_err on acceptance.
- Precedence, ignored inputs and reset:
  - read+write+mdr_in together → only mem_rd asserted.
  - mdr_in during RD_WAIT has no effect.
  - clr asserted mid-RD_WAIT → all outputs 0 immediately (asynchronously); no done pulse.

Source files
------------

// File: rtl/mdr_pkg.sv
// mdr_pkg: shared FSM state and access-size encodings for the MDR unit
package mdr_pkg;
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
endpackage

// File: rtl/mdr_unit_if.sv
// mdr_unit_if: bus/memory/control signals of the MDR; master drives requests and memory responses, slave is the MDR
interface mdr_unit_if #(parameter int DATA_W = 32);
   logic [DATA_W-1:0] bus_mux_out;
   logic              mdr_in;
   logic              read;
   logic              write;
   logic [1:0]        size;
   logic              sign_ext;
   logic [1:0]        addr_lo;
   logic [DATA_W-1:0] mem_data_in;
   logic              mem_ack;
   logic              mem_rd;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_data_out;
   logic [DATA_W-1:0] mdr_q;
   logic              busy;
   logic              done;
   logic              timeout_err;
   modport master (
      output bus_mux_out, mdr_in, read, write, size, sign_ext, addr_lo, mem_data_in, mem_ack,
      input  mem_rd, mem_wr, mem_data_out, mdr_q, busy, done, timeout_err
   );
   modport slave (
      input  bus_mux_out, mdr_in, read, write, size, sign_ext, addr_lo, mem_data_in, mem_ack,
      output mem_rd, mem_wr, mem_data_out, mdr_q, busy, done, timeout_err
   );
endinterface

// File: rtl/mdr_extract.sv
// mdr_extract: byte/half/word lane select with sign or zero extension (in: data,size,sign_ext,addr_lo; out: ext)
module mdr_extract
   import mdr_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] data,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [1:0]        addr_lo,
   output logic [DATA_W-1:0] ext
);
   // sub-word lanes always come from the low 32 bits, zero-padded when DATA_W is narrower
   localparam int LW = DATA_W < 32 ? DATA_W : 32;
   logic [31:0] lo;
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      lo  = 32'(data[LW-1:0]);
      b   = lo[8*addr_lo +: 8];
      h   = lo[16*addr_lo[1] +: 16];
      ext = size == SZ_BYTE ? (sign_ext ? DATA_W'($signed(b)) : DATA_W'(b)) :
            size == SZ_HALF ? (sign_ext ? DATA_W'($signed(h)) : DATA_W'(h)) : data;
   end
endmodule

// File: rtl/mdr_unit.sv
// mdr_unit: memory data register with bus load, timed memory read/write handshake and done/busy control (ports: clk, clr async reset, bus slave modport)
module mdr_unit
   import mdr_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input logic        clk,
   input logic        clr,
   mdr_unit_if.slave  bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mdr_q, mdr_d, ext;
   logic [1:0]        size_q, size_d, alo_q, alo_d;
   logic              sx_q, sx_d, terr_q, terr_d;
   // extraction uses the access parameters captured at read acceptance
   mdr_extract #(.DATA_W(DATA_W)) u_ext (
      .data(bus.mem_data_in), .size(size_q), .sign_ext(sx_q), .addr_lo(alo_q), .ext(ext)
   );
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mdr_q   <= '0;
         size_q  <= SZ_WORD;
         sx_q    <= 1'b0;
         alo_q   <= 2'b00;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mdr_q   <= mdr_d;
         size_q  <= size_d;
         sx_q    <= sx_d;
         alo_q   <= alo_d;
         terr_q  <= terr_d;
      end
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mdr_d   = mdr_q;
      size_d  = size_q;
      sx_d    = sx_q;
      alo_d   = alo_q;
      terr_d  = terr_q;
      case (state_q)
         IDLE:
            if (bus.read) begin
               size_d  = bus.size;
               sx_d    = bus.sign_ext;
               alo_d   = bus.addr_lo;
               cnt_d   = '0;
               terr_d  = 1'b0;
               state_d = RD_WAIT;
            end else if (bus.write) begin
               cnt_d   = '0;
               terr_d  = 1'b0;
               state_d = WR_WAIT;
            end else if (bus.mdr_in) mdr_d = bus.bus_mux_out;
         RD_WAIT, WR_WAIT:
            // an ack in the final counted cycle wins over the timeout
            if (bus.mem_ack) begin
               if (state_q == RD_WAIT) mdr_d = ext;
               state_d = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               terr_d  = 1'b1;
               state_d = DONE;
            end else cnt_d = cnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end
   assign bus.mem_rd       = state_q == RD_WAIT;
   assign bus.mem_wr       = state_q == WR_WAIT;
   assign bus.busy         = state_q == RD_WAIT || state_q == WR_WAIT;
   assign bus.done         = state_q == DONE;
   assign bus.mem_data_out = mdr_q;
   assign bus.mdr_q        = mdr_q;
   assign bus.timeout_err  = terr_q;
endmodule

// File: tb/tb_mdr_unit.sv
// tb_mdr_unit: table-driven read/write transfers with a scoreboard plus hand-written corner sequences
module tb_mdr_unit;
   import mdr_pkg::*;
   localparam int DW = 32;
   localparam int TO = 15;
   logic clk = 1'b0;
   logic clr = 1'b1;
   mdr_unit_if #(.DATA_W(DW)) ifc ();
   mdr_unit #(.DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .clr(clr), .bus(ifc));
   always #5 clk = ~clk;
   int n_cmp = 0;
   int n_bad = 0;
   logic [DW-1:0] sb_q[$];
   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        sx;
      logic [1:0]  alo;
      logic [31:0] data;
      int          lat;
      logic [31:0] exp;
      int          exp_cyc;
      logic        exp_err;
   } vec_t;
   vec_t v[10];
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic xfer(vec_t t);
      int cyc = 0;
      logic stable = 1'b1;
      logic other_low = 1'b1;
      logic [DW-1:0] e;
      ifc.read     = !t.wr;
      ifc.write    = t.wr;
      ifc.size     = t.size;
      ifc.sign_ext = t.sx;
      ifc.addr_lo  = t.alo;
      sb_q.push_back(t.exp);
      @(negedge clk);
      ifc.read  = 1'b0;
      ifc.write = 1'b0;
      chk("busy_on_accept", 32'(ifc.busy), 1);
      chk("terr_cleared", 32'(ifc.timeout_err), 0);
      while ((t.wr ? ifc.mem_wr : ifc.mem_rd) && cyc < 40) begin
         cyc++;
         if (t.wr && ifc.mem_data_out !== t.exp) stable = 1'b0;
         if (t.wr ? ifc.mem_rd : ifc.mem_wr) other_low = 1'b0;
         ifc.mem_ack     = (cyc == t.lat);
         ifc.mem_data_in = t.data;
         @(negedge clk);
      end
      ifc.mem_ack = 1'b0;
      chk("req_cycles", cyc, t.exp_cyc);
      chk("wdata_stable", 32'(stable), 1);
      chk("other_req_low", 32'(other_low), 1);
      chk("done_pulse", 32'(ifc.done), 1);
      chk("timeout_err", 32'(ifc.timeout_err), 32'(t.exp_err));
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard: got empty queue expected one entry");
      end else begin
         e = sb_q.pop_front();
         chk("mdr_q", ifc.mdr_q, e);
      end
      @(negedge clk);
      chk("done_one_cycle", 32'(ifc.done), 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end
   initial begin
      int bad_done = 0;
      ifc.bus_mux_out = '0;
      ifc.mdr_in      = 1'b0;
      ifc.read        = 1'b0;
      ifc.write       = 1'b0;
      ifc.size        = SZ_WORD;
      ifc.sign_ext    = 1'b0;
      ifc.addr_lo     = 2'b00;
      ifc.mem_data_in = '0;
      ifc.mem_ack     = 1'b0;
      //            wr size     sx alo  data          lat exp           cyc err
      v[0] = '{1'b0, SZ_WORD, 1'b0, 2'd0, 32'h12345678, 3,  32'h12345678, 3,  1'b0};
      v[1] = '{1'b0, SZ_BYTE, 1'b1, 2'd2, 32'h00A50000, 1,  32'hFFFFFFA5, 1,  1'b0};
      v[2] = '{1'b0, SZ_BYTE, 1'b0, 2'd2, 32'h00A50000, 1,  32'h000000A5, 1,  1'b0};
      v[3] = '{1'b0, SZ_HALF, 1'b1, 2'd3, 32'h80010000, 1,  32'hFFFF8001, 1,  1'b0};
      v[4] = '{1'b1, SZ_WORD, 1'b0, 2'd0, 32'h0,        2,  32'hFFFF8001, 2,  1'b0};
      v[5] = '{1'b0, SZ_BYTE, 1'b1, 2'd0, 32'h0000007F, 2,  32'h0000007F, 2,  1'b0};
      v[6] = '{1'b0, SZ_HALF, 1'b0, 2'd0, 32'h1234F00D, 4,  32'h0000F00D, 4,  1'b0};
      v[7] = '{1'b0, SZ_WORD, 1'b1, 2'd0, 32'h87654321, TO, 32'h87654321, TO, 1'b0};
      v[8] = '{1'b0, SZ_BYTE, 1'b1, 2'd3, 32'h80000000, 1,  32'hFFFFFF80, 1,  1'b0};
      v[9] = '{1'b0, SZ_WORD, 1'b0, 2'd0, 32'hAAAAAAAA, 0,  32'hFFFFFF80, TO, 1'b1};
      repeat (2) @(negedge clk);
      chk("rst_mdr_q", ifc.mdr_q, 0);
      chk("rst_mem_rd", 32'(ifc.mem_rd), 0);
      chk("rst_mem_wr", 32'(ifc.mem_wr), 0);
      chk("rst_busy", 32'(ifc.busy), 0);
      chk("rst_done", 32'(ifc.done), 0);
      chk("rst_terr", 32'(ifc.timeout_err), 0);
      clr = 1'b0;
      @(negedge clk);
      ifc.mdr_in      = 1'b1;
      ifc.bus_mux_out = 32'hDEADBEEF;
      @(negedge clk);
      ifc.mdr_in = 1'b0;
      chk("bus_load", ifc.mdr_q, 32'hDEADBEEF);
      chk("bus_load_busy", 32'(ifc.busy), 0);
      chk("bus_load_done", 32'(ifc.done), 0);
      ifc.mem_ack     = 1'b1;
      ifc.mem_data_in = 32'h55555555;
      @(negedge clk);
      ifc.mem_ack = 1'b0;
      chk("stray_ack_mdr", ifc.mdr_q, 32'hDEADBEEF);
      chk("stray_ack_busy", 32'(ifc.busy), 0);
      for (int i = 0; i < 10; i++) xfer(v[i]);
      chk("terr_sticky", 32'(ifc.timeout_err), 1);
      xfer('{1'b1, SZ_WORD, 1'b0, 2'd0, 32'h0, 1, 32'hFFFFFF80, 1, 1'b0});
      ifc.read        = 1'b1;
      ifc.write       = 1'b1;
      ifc.mdr_in      = 1'b1;
      ifc.size        = SZ_WORD;
      ifc.bus_mux_out = 32'h11111111;
      @(negedge clk);
      ifc.read  = 1'b0;
      ifc.write = 1'b0;
      ifc.bus_mux_out = 32'h22222222;
      chk("prec_mem_rd", 32'(ifc.mem_rd), 1);
      chk("prec_mem_wr", 32'(ifc.mem_wr), 0);
      chk("prec_mdr_kept", ifc.mdr_q, 32'hFFFFFF80);
      @(negedge clk);
      ifc.mdr_in = 1'b0;
      chk("busy_mdr_in_ignored", ifc.mdr_q, 32'hFFFFFF80);
      ifc.mem_ack     = 1'b1;
      ifc.mem_data_in = 32'hCAFEBABE;
      @(negedge clk);
      ifc.mem_ack = 1'b0;
      chk("prec_done", 32'(ifc.done), 1);
      chk("prec_mdr", ifc.mdr_q, 32'hCAFEBABE);
      @(negedge clk);
      ifc.read = 1'b1;
      @(negedge clk);
      ifc.read = 1'b0;
      @(negedge clk);
      chk("pre_rst_mem_rd", 32'(ifc.mem_rd), 1);
      clr = 1'b1;
      #1;
      chk("async_rst_mem_rd", 32'(ifc.mem_rd), 0);
      chk("async_rst_busy", 32'(ifc.busy), 0);
      chk("async_rst_done", 32'(ifc.done), 0);
      chk("async_rst_mdr", ifc.mdr_q, 0);
      @(negedge clk);
      clr = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (ifc.done !== 1'b0) bad_done++;
      end
      chk("no_done_after_rst", bad_done, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
